// File: rtl/key_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_sync
// Description : Debouncer for a raw push-button / switch input. The raw level
//               is brought into the clk domain by a two-flop synchronizer and
//               then qualified by a four-state FSM. key_level only changes
//               after STABLE_CYCLES consecutive synchronized samples that
//               differ from the current level. Single-cycle registered edge
//               pulses accompany every debounced transition.
//
// Ports       : clk       - single clock, rising edge
//               rst       - synchronous active-high reset
//               key_in    - raw asynchronous key level
//               key_level - debounced level (registered)
//               key_rise  - one-cycle pulse on debounced 0->1 (registered)
//               key_fall  - one-cycle pulse on debounced 1->0 (registered)
//
// Parameters  : STABLE_CYCLES - qualifying samples required, 2..65535
//
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_sync #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_rise,
    output logic key_fall
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // Count value at which the final qualifying sample completes the change.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic               r_s1;
    logic               r_s2;
    logic [c_CNT_W-1:0] r_cnt;
    state_t             r_state;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. Only r_s2 is considered safe to decide on.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Qualification FSM with registered outputs.
    // Entering a WAIT state counts the first differing sample (cnt = 1); any
    // sample matching the current level aborts back to IDLE with no credit
    // kept, so only an unbroken run of STABLE_CYCLES samples changes the level.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= c_CNT_ZERO;
            key_level <= 1'b0;
            key_rise  <= 1'b0;
            key_fall  <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            key_rise <= 1'b0;
            key_fall <= 1'b0;

            case (r_state)
                IDLE_LOW: begin
                    if (r_s2) begin
                        r_cnt   <= c_CNT_ONE;
                        r_state <= WAIT_HIGH;
                    end else begin
                        r_cnt   <= c_CNT_ZERO;
                    end
                end

                WAIT_HIGH: begin
                    if (!r_s2) begin
                        // Bounce: restart qualification from scratch.
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= IDLE_LOW;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cnt     <= c_CNT_ZERO;
                        r_state   <= IDLE_HIGH;
                        key_level <= 1'b1;
                        key_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!r_s2) begin
                        r_cnt   <= c_CNT_ONE;
                        r_state <= WAIT_LOW;
                    end else begin
                        r_cnt   <= c_CNT_ZERO;
                    end
                end

                WAIT_LOW: begin
                    if (r_s2) begin
                        // Glitch low while released-pending: keep level high.
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= IDLE_HIGH;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_cnt     <= c_CNT_ZERO;
                        r_state   <= IDLE_LOW;
                        key_level <= 1'b0;
                        key_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_cnt     <= c_CNT_ZERO;
                    r_state   <= IDLE_LOW;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_sync
// Description : Directed self-checking bench for key_debounce_sync with
//               STABLE_CYCLES = 4 and a 10 ns clock. A level change on key_in
//               ahead of edge k is captured by s1 at k and s2 at k+1, and the
//               FSM then needs four consecutive s2 samples (edges k+2..k+5),
//               so the debounced outputs change at edge k+5.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_sync;

    localparam int c_STABLE = 4;

    logic clk;
    logic rst;
    logic key_in;
    logic key_level;
    logic key_rise;
    logic key_fall;

    int total = 0;
    int bad   = 0;
    int n_rise = 0;
    int n_fall = 0;
    int n_both = 0;

    key_debounce_sync #(
        .STABLE_CYCLES (c_STABLE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .key_rise  (key_rise),
        .key_fall  (key_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 ns; pulses seen in this cycle are tallied.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (key_rise)             n_rise++;
        if (key_fall)             n_fall++;
        if (key_rise && key_fall) n_both++;
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic lvl, input logic r, input logic f);
        check_bit({tag, ".level"}, key_level, lvl);
        check_bit({tag, ".rise"},  key_rise,  r);
        check_bit({tag, ".fall"},  key_fall,  f);
    endtask

    // Bounce pattern: value and number of cycles it is held.
    logic bounce_val [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   bounce_len [4] = '{2, 2, 3, 1};

    initial begin
        rst    = 1'b1;
        key_in = 1'b1;

        // ---------------- Reset held 3 cycles with key_in = 1 ---------------
        repeat (3) cyc();
        check_out("reset", 1'b0, 1'b0, 1'b0);

        rst    = 1'b0;
        n_rise = 0;
        n_fall = 0;
        repeat (5) cyc();
        check_out("rst_rel_k4", 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("rst_rel_k5", 1'b1, 1'b1, 1'b0);
        cyc();
        check_out("rst_rel_k6", 1'b1, 1'b0, 1'b0);
        check_int("rst_rel_nrise", n_rise, 1);

        // ---------------- Release: 1 -> 0 held ------------------------------
        n_rise = 0;
        n_fall = 0;
        key_in = 1'b0;
        repeat (5) cyc();
        check_out("release_k4", 1'b1, 1'b0, 1'b0);
        cyc();
        check_out("release_k5", 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("release_k6", 1'b0, 1'b0, 1'b0);
        check_int("release_nfall", n_fall, 1);

        // ---------------- Clean press: 0 -> 1 held --------------------------
        n_rise = 0;
        n_fall = 0;
        key_in = 1'b1;
        repeat (5) cyc();
        check_out("press_k4", 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("press_k5", 1'b1, 1'b1, 1'b0);
        cyc();
        check_out("press_k6", 1'b1, 1'b0, 1'b0);
        check_int("press_nrise", n_rise, 1);
        check_int("press_nfall", n_fall, 0);

        // ---------------- Glitch low for 3 cycles is rejected ---------------
        n_rise = 0;
        n_fall = 0;
        key_in = 1'b0;
        repeat (3) cyc();
        key_in = 1'b1;
        repeat (10) cyc();
        check_out("glitch3", 1'b1, 1'b0, 1'b0);
        check_int("glitch3_nfall", n_fall, 0);

        // ---------------- Low for exactly 4 cycles qualifies ----------------
        // key_in low ahead of edges g..g+3: fall at g+5, then the return to
        // high (ahead of g+4) re-qualifies and rises at g+9.
        n_rise = 0;
        n_fall = 0;
        key_in = 1'b0;
        repeat (4) cyc();
        key_in = 1'b1;
        repeat (2) cyc();
        check_out("low4_fall", 1'b0, 1'b0, 1'b1);
        repeat (4) cyc();
        check_out("low4_rise", 1'b1, 1'b1, 1'b0);
        check_int("low4_nfall", n_fall, 1);

        // Return to low for the bounce test.
        key_in = 1'b0;
        repeat (8) cyc();
        check_out("settle_low", 1'b0, 1'b0, 1'b0);

        // ---------------- Bounce filter -------------------------------------
        // Runs 1x2, 0x2, 1x3, 0x1 never give four consecutive high samples.
        n_rise = 0;
        n_fall = 0;
        for (int i = 0; i < 4; i++) begin
            key_in = bounce_val[i];
            repeat (bounce_len[i]) cyc();
        end
        check_out("bounce_end", 1'b0, 1'b0, 1'b0);
        check_int("bounce_nrise", n_rise, 0);
        key_in = 1'b1;
        repeat (5) cyc();
        check_out("bounce_k4", 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("bounce_k5", 1'b1, 1'b1, 1'b0);
        check_int("bounce_nrise_final", n_rise, 1);

        // ---------------- Reset mid-qualification ---------------------------
        key_in = 1'b0;
        repeat (8) cyc();
        check_out("pre_mid_low", 1'b0, 1'b0, 1'b0);
        n_rise = 0;
        n_fall = 0;
        key_in = 1'b1;
        repeat (5) cyc();
        check_out("mid_k4", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;             // edge k+5 would have completed WAIT_HIGH
        cyc();
        check_out("mid_rst", 1'b0, 1'b0, 1'b0);
        check_int("mid_rst_nrise", n_rise, 0);
        rst = 1'b0;
        repeat (5) cyc();
        check_out("mid_rel_k4", 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("mid_rel_k5", 1'b1, 1'b1, 1'b0);
        cyc();
        check_out("mid_rel_k6", 1'b1, 1'b0, 1'b0);
        check_int("mid_rel_nrise", n_rise, 1);

        check_int("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
